// File: rtl/maxex_k_sequencer_if.sv
// Bundles the job, operand, reduction-unit and result signals of the K-chunk sequencer.
// master = job source / operand feeder / result consumer / reduction unit; slave = sequencer.
interface maxex_k_sequencer_if #(
    parameter int W  = 16,
    parameter int KW = 8
);
    logic            start;
    logic            func_in;
    logic [KW-1:0]   nsteps;
    logic [W-1:0]    init;
    logic            busy;

    logic            op_valid;
    logic            op_ready;
    logic [8*W-1:0]  op_data;

    logic [8*W-1:0]  u_ops;
    logic [W-1:0]    u_e;
    logic            u_func;
    logic [W-1:0]    u_out;

    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_data;

    modport master (
        output start, func_in, nsteps, init, op_valid, op_data, u_out, res_ready,
        input  busy, op_ready, u_ops, u_e, u_func, res_valid, res_data
    );

    modport slave (
        input  start, func_in, nsteps, init, op_valid, op_data, u_out, res_ready,
        output busy, op_ready, u_ops, u_e, u_func, res_valid, res_data
    );
endinterface

// File: rtl/maxex_k_sequencer.sv
// K-beat semiring dot-product sequencer around a combinational max-plus/max-times unit; optional MAXEX_SEQ_PIPE_EN.
// Latency: result valid 1 cycle after last beat (2 with MAXEX_SEQ_PIPE_EN), 1 cycle after start when nsteps=0.
// Backpressure: op_valid low stalls with acc held; res_ready low holds DONE and all result outputs stable.
module maxex_k_sequencer #(
    parameter int W  = 16,
    parameter int KW = 8
) (
    input  logic               clk,
    input  logic               rst,
    maxex_k_sequencer_if.slave bus
);

`ifdef MAXEX_SEQ_PIPE_EN
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    localparam logic [KW-1:0] CNT_ONE = {{(KW-1){1'b0}}, 1'b1};

    state_t          state, state_n;
    logic [W-1:0]    acc, acc_n;
    logic [KW-1:0]   cnt, cnt_n;
    logic [KW-1:0]   nsteps_q, nsteps_n;
    logic            func_q, func_n;
    logic            op_ready_c;
    logic            res_valid_c;
    logic            last_beat;
`ifdef MAXEX_SEQ_PIPE_EN
    logic [8*W-1:0]  ops_q, ops_n;
`endif

    // nsteps_q is nonzero whenever a beat is being consumed, so the subtraction cannot underflow
    assign last_beat = (cnt == (nsteps_q - CNT_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            nsteps_q <= '0;
            func_q   <= 1'b0;
`ifdef MAXEX_SEQ_PIPE_EN
            ops_q    <= '0;
`endif
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            nsteps_q <= nsteps_n;
            func_q   <= func_n;
`ifdef MAXEX_SEQ_PIPE_EN
            ops_q    <= ops_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        nsteps_n    = nsteps_q;
        func_n      = func_q;
        op_ready_c  = 1'b0;
        res_valid_c = 1'b0;
`ifdef MAXEX_SEQ_PIPE_EN
        ops_n       = ops_q;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    func_n   = bus.func_in;
                    nsteps_n = bus.nsteps;
                    acc_n    = bus.init;
                    cnt_n    = '0;
`ifdef MAXEX_SEQ_PIPE_EN
                    state_n  = (bus.nsteps == '0) ? DONE : ISSUE;
`else
                    state_n  = (bus.nsteps == '0) ? DONE : RUN;
`endif
                end
            end
`ifdef MAXEX_SEQ_PIPE_EN
            ISSUE: begin
                op_ready_c = 1'b1;
                if (bus.op_valid) begin
                    ops_n   = bus.op_data;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                acc_n   = bus.u_out;
                cnt_n   = cnt + CNT_ONE;
                state_n = last_beat ? DONE : ISSUE;
            end
`else
            RUN: begin
                op_ready_c = 1'b1;
                if (bus.op_valid) begin
                    acc_n = bus.u_out;
                    cnt_n = cnt + CNT_ONE;
                    if (last_beat) begin
                        state_n = DONE;
                    end
                end
            end
`endif
            DONE: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.op_ready  = op_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = (state == DONE) ? acc : '0;
    assign bus.u_e       = acc;
    assign bus.u_func    = func_q;
`ifdef MAXEX_SEQ_PIPE_EN
    assign bus.u_ops     = ops_q;
`else
    assign bus.u_ops     = bus.op_data;
`endif

endmodule

// File: tb/tb_maxex_k_sequencer.sv
// Directed table-driven bench for maxex_k_sequencer with a behavioural reduction unit on u_out.
module tb_maxex_k_sequencer;
    localparam int W  = 16;
    localparam int KW = 8;
`ifdef MAXEX_SEQ_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic          f;
        logic [W-1:0]  ini;
        logic [KW-1:0] n;
        logic [127:0]  beat;
        logic [W-1:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl [6];

    always #5 clk = ~clk;

    maxex_k_sequencer_if #(.W(W), .KW(KW)) bus ();

    maxex_k_sequencer #(.W(W), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [W-1:0] unit_ref(input logic [127:0] o, input logic [W-1:0] e, input logic f);
        logic [W-1:0] m, x, y, r;
        m = e;
        for (int i = 0; i < 4; i++) begin
            x = o[127-32*i -: 16];
            y = o[111-32*i -: 16];
            r = f ? 16'(x * y) : 16'(x + y);
            if (r > m) m = r;
        end
        return m;
    endfunction

    always_comb bus.u_out = unit_ref(bus.u_ops, bus.u_e, bus.u_func);

    function automatic logic [127:0] pk(input logic [15:0] a1, a2, b1, b2, c1, c2, d1, d2);
        return {a1, a2, b1, b2, c1, c2, d1, d2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Job inputs are scrambled right after start to prove they were latched.
    task automatic start_job(input logic f, input logic [W-1:0] ini, input logic [KW-1:0] n);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.func_in = f;
        bus.nsteps  = n;
        bus.init    = ini;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.func_in = ~f;
        bus.nsteps  = '1;
        bus.init    = 16'hDEAD;
    endtask

    task automatic send_beat(input logic [127:0] d);
        int g = 0;
        bus.op_valid = 1'b1;
        bus.op_data  = d;
        while (!bus.op_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("op_ready_wait", {31'b0, g < 10}, 1);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op_data  = '0;
    endtask

    task automatic wait_result(input string name, input logic [W-1:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 8);
        chk({name, "_latency"}, n, LAT);
        chk({name, "_res_data"}, bus.res_data, exp);
    endtask

    task automatic take_result(input string name);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk({name, "_busy_after"}, bus.busy, 0);
        chk({name, "_res_valid_after"}, bus.res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 16'd5,      8'd1, pk(3, 4, 2, 5, 1, 1, 0, 9),                   16'd12};
        tbl[1] = '{1'b0, 16'd0,      8'd1, pk(16'hFFFF, 2, 0, 0, 0, 0, 0, 0),            16'h0001};
        tbl[2] = '{1'b0, 16'd100,    8'd1, pk(1, 2, 3, 4, 0, 0, 0, 0),                   16'd100};
        tbl[3] = '{1'b1, 16'd3,      8'd1, pk(16'h100, 16'h100, 0, 0, 0, 0, 0, 0),       16'd3};
        tbl[4] = '{1'b0, 16'h1234,   8'd0, pk(0, 0, 0, 0, 0, 0, 0, 0),                   16'h1234};
        tbl[5] = '{1'b1, 16'd0,      8'd1, pk(16'hFFFF, 16'hFFFF, 2, 3, 0, 0, 0, 0),     16'd6};

        rst = 1'b1;
        bus.start = 1'b0; bus.func_in = 1'b0; bus.nsteps = '0; bus.init = '0;
        bus.op_valid = 1'b0; bus.op_data = '0; bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_op_ready", bus.op_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_u_e", bus.u_e, 0);
        chk("rst_u_func", bus.u_func, 0);
        rst = 1'b0;

        // Two-beat max-plus, with start pulsed mid-job
        start_job(1'b0, 16'd0, 8'd2);
        send_beat(pk(1, 2, 3, 4, 5, 0, 0, 1));
        repeat (LAT) @(negedge clk);
        chk("mp2_acc_beat1", bus.u_e, 7);
        chk("mp2_res_valid_mid", bus.res_valid, 0);
        bus.start = 1'b1;
        bus.nsteps = '0;
        send_beat(pk(10, 10, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b0;
        wait_result("mp2", 16'd20);
        take_result("mp2");

        for (int i = 0; i < 6; i++) begin
            start_job(tbl[i].f, tbl[i].ini, tbl[i].n);
            if (tbl[i].n == 0) begin
                chk($sformatf("v%0d_res_valid", i), bus.res_valid, 1);
                chk($sformatf("v%0d_res_data", i), bus.res_data, tbl[i].exp);
                chk($sformatf("v%0d_op_ready", i), bus.op_ready, 0);
            end else begin
                chk($sformatf("v%0d_u_func", i), bus.u_func, tbl[i].f);
                send_beat(tbl[i].beat);
                wait_result($sformatf("v%0d", i), tbl[i].exp);
            end
            take_result($sformatf("v%0d", i));
        end

        // Result backpressure with start and op_valid held high
        start_job(1'b0, 16'd0, 8'd1);
        send_beat(pk(16'h40, 16'h2, 0, 0, 0, 0, 0, 0));
        wait_result("bp", 16'h42);
        bus.start = 1'b1; bus.op_valid = 1'b1; bus.nsteps = '0; bus.init = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_res_data", i), bus.res_data, 16'h42);
            chk($sformatf("bp%0d_res_valid", i), bus.res_valid, 1);
            chk($sformatf("bp%0d_op_ready", i), bus.op_ready, 0);
            chk($sformatf("bp%0d_busy", i), bus.busy, 1);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0; bus.start = 1'b0; bus.op_valid = 1'b0;
        chk("bp_idle_busy", bus.busy, 0);
        chk("bp_idle_res_valid", bus.res_valid, 0);
        @(negedge clk);
        chk("bp_idle_stays", bus.busy, 0);

        // Reset in the middle of a three-beat job
        start_job(1'b0, 16'd0, 8'd3);
        send_beat(pk(1, 2, 3, 4, 5, 0, 0, 1));
        repeat (LAT) @(negedge clk);
        chk("rj_acc_beat1", bus.u_e, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rj_busy", bus.busy, 0);
        chk("rj_res_valid", bus.res_valid, 0);
        chk("rj_acc", bus.u_e, 0);
        start_job(1'b0, 16'd0, 8'd1);
        send_beat(pk(1, 1, 0, 0, 0, 0, 0, 0));
        wait_result("rj_next", 16'd2);
        take_result("rj_next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/maxex_k_sequencer.md
Name: maxex_k_sequencer

Overview:
- Upstream/feedback controller for the combinational max-plus/max-times reduction unit (4 operand pairs plus an accumulator input e, `func` selects plus or times).
- Streams K-chunks of 8 operands into the unit and drives e from a running accumulator register.
- Captures the unit's output each beat and emits the final reduced element over a valid/ready result port.
- Turns the one-shot combinational unit into a K-length semiring dot-product engine.

Parameters:
- W, 16, operand/accumulator width; must match the reduction unit.
- KW, 8, width of the beat-count field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin job; sampled only in IDLE
- func_in  in  1  0 = max-plus, 1 = max-times; latched at start
- nsteps  in  KW  number of operand beats in the job; latched at start
- init  in  W  accumulator initial value; latched at start
- busy  out  1  high in every state except IDLE
- op_valid  in  1  operand beat valid
- op_ready  out  1  sequencer accepts operand beat
- op_data  in  8*W  packed {a1,a2,b1,b2,c1,c2,d1,d2}, a1 at MSB
- u_ops  out  8*W  operands to reduction unit, same packing
- u_e  out  W  accumulator to unit e input; always equals acc
- u_func  out  1  latched func
- u_out  in  W  reduction unit result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  W  final accumulator

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, acc=0, cnt=0, func_q=0, nsteps_q=0, ops_q=0. Outputs: busy=0, op_ready=0, res_valid=0, res_data=0, u_e=0, u_func=0.
- Reset mid-job: aborts the job. No result is emitted and partial acc is discarded.
- IDLE:
  - start=1 latches func_q, nsteps_q, init into acc, and sets cnt=0.
  - If nsteps=0, next state is DONE with res_data=init.
  - Otherwise next state is RUN (ISSUE in pipelined build).
  - op_valid is ignored in IDLE.
- start outside IDLE is ignored, with no effect on the running job.
- RUN (default build, macro undefined):
  - op_ready=1 and u_ops=op_data combinationally.
  - On op_valid&op_ready: acc<=u_out, cnt<=cnt+1. When cnt==nsteps_q-1, next state is DONE.
  - Throughput is 1 beat/cycle. op_valid low stalls with acc unchanged.
- DONE:
  - res_valid=1 and res_data=acc.
  - All result outputs hold stable until res_ready=1, then the next state is IDLE.
  - Result handshake takes one cycle minimum. start in the handshake cycle is ignored.
- Arithmetic: the unit computes modulo 2^W with unsigned compare. The sequencer never modifies u_out beyond capture.
- Latency: result valid the cycle after the last beat handshake. For nsteps=0, result valid the cycle after start.
- nsteps_q counts up to 2^KW-1 beats. cnt is KW bits and never wraps within a job.

Optional Feature:
- Macro: MAXEX_SEQ_PIPE_EN.
- When defined, RUN splits into two states:
  - ISSUE: op_ready=1. On handshake, ops_q<=op_data and next state is CAPTURE.
  - CAPTURE: op_ready=0 and u_ops=ops_q. acc<=u_out, cnt<=cnt+1; next state is DONE if last beat, else ISSUE.
- u_ops is always driven from ops_q in this build.
- Throughput is 1 beat per 2 cycles. There is no combinational path from op_data to acc.
- Result timing is the cycle after CAPTURE of the last beat.
- When undefined: single RUN state as above.

Test Plan:
- Max-plus, func=0, init=0, nsteps=2:
  - beat1 {1,2,3,4,5,0,0,1} then beat2 {10,10,0,0,0,0,0,0}.
  - Required: acc=7 after beat1; res_data=20 with res_valid 1 cycle after beat2 (2 cycles in PIPE build).
- Max-times, func=1, init=5, nsteps=1, beat {3,4,2,5,1,1,0,9} -> res_data=12.
- Wrap: W=16, func=0, init=0, nsteps=1, beat {0xFFFF,2,0,0,0,0,0,0} -> res_data=0x0001.
- nsteps=0, init=0x1234 -> no op_ready ever asserted; res_valid=1, res_data=0x1234 the cycle after start.
- Backpressure: hold res_ready=0 for 5 cycles with start pulsed and op_valid=1 -> res_data stable, op_ready=0, busy=1, start ignored; res_ready=1 -> IDLE next cycle.
- Reset mid-job: nsteps=3, assert rst after beat1 -> next cycle busy=0, res_valid=0, acc=0; a following job (max-plus, init=0, nsteps=1, {1,1,0,0,0,0,0,0}) returns 2.
